// File: rtl/c3demo_send_arbiter.sv
// Round-robin, burst-limited arbiter sharing one byte send stream between NUM_EP producers.
// Optional macro C3DEMO_SEND_ARB_PRIO_EN adds prio_mask to restrict the IDLE scan to priority requesters.
module c3demo_send_arbiter #(
  parameter int unsigned NUM_EP    = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_EP-1:0]   req_valid,
  output logic [NUM_EP-1:0]   req_ready,
  input  logic [8*NUM_EP-1:0] req_data,
`ifdef C3DEMO_SEND_ARB_PRIO_EN
  input  logic [NUM_EP-1:0]   prio_mask,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [7:0]          out_epnum,
  output logic [NUM_EP-1:0]   grant,
  output logic                busy
);

  localparam int unsigned PW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [NUM_EP-1:0] grant_q,     grant_d;
  logic [PW-1:0]     gidx_q,      gidx_d;
  logic [PW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;

  logic [NUM_EP-1:0] cand;
  logic              sel_found;
  logic [PW-1:0]     sel_idx;
  int unsigned       scan_idx;
  logic              xfer;

  // Circular scan from rr_ptr; wrap at NUM_EP is explicit so non-power-of-2 counts work.
  always_comb begin
    cand      = req_valid;
`ifdef C3DEMO_SEND_ARB_PRIO_EN
    if (|(req_valid & prio_mask)) cand = req_valid & prio_mask;
`endif
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_EP; k++) begin
      scan_idx = 32'(rr_ptr_q) + k;
      if (scan_idx >= NUM_EP) scan_idx = scan_idx - NUM_EP;
      if (!sel_found && cand[PW'(scan_idx)]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(scan_idx);
      end
    end
  end

  // Stream mux is purely combinational from the registered one-hot grant.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (grant_q[i]) begin
        out_valid = req_valid[i];
        out_data  = req_data[8*i +: 8];
      end
    end
    req_ready = grant_q & {NUM_EP{out_ready}};
    busy      = (state_q == ST_GRANT);
    out_epnum = busy ? 8'(gidx_q) : 8'h00;
    grant     = grant_q;
  end

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d     = ST_GRANT;
          grant_d     = NUM_EP'(1) << sel_idx;
          gidx_d      = sel_idx;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // End of packet or burst limit reached; backpressure alone never releases.
        if (!out_valid || (xfer && (burst_cnt_q == CW'(MAX_BURST - 1)))) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == PW'(NUM_EP - 1)) ? '0 : gidx_q + PW'(1);
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_c3demo_send_arbiter.sv
// Directed self-checking bench for c3demo_send_arbiter (NUM_EP=4, MAX_BURST=16).
module tb_c3demo_send_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
`ifdef C3DEMO_SEND_ARB_PRIO_EN
  logic [3:0]  prio_mask;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_epnum;
  logic [3:0]  grant;
  logic        busy;

  int n_cmp;
  int n_err;

  c3demo_send_arbiter #(.NUM_EP(4), .MAX_BURST(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
`ifdef C3DEMO_SEND_ARB_PRIO_EN
    .prio_mask (prio_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_epnum (out_epnum),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef C3DEMO_SEND_ARB_PRIO_EN
    prio_mask = 4'b0000;
`endif
    do_reset();
    resetn = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_grant",     32'(grant),     32'h0);
    check_eq("rst_busy",      32'(busy),      32'h0);
    check_eq("rst_epnum",     32'(out_epnum), 32'h0);
    check_eq("rst_data",      32'(out_data),  32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    do_reset();

    // EP2 alone: three bytes, then end of packet.
    req_valid = 4'b0100;
    req_data[23:16] = 8'h11;
    #1;
    check_eq("ep2_arb_cycle_grant", 32'(grant), 32'h0);
    tick();
    check_eq("ep2_grant",     32'(grant),     32'h4);
    check_eq("ep2_epnum",     32'(out_epnum), 32'h2);
    check_eq("ep2_busy",      32'(busy),      32'h1);
    check_eq("ep2_req_ready", 32'(req_ready), 32'h4);
    check_eq("ep2_b0",        32'(out_data),  32'h11);
    tick();
    req_data[23:16] = 8'h22;
    #1;
    check_eq("ep2_b1", 32'(out_data), 32'h22);
    tick();
    req_data[23:16] = 8'h33;
    #1;
    check_eq("ep2_b2", 32'(out_data), 32'h33);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("ep2_eop_valid", 32'(out_valid), 32'h0);
    check_eq("ep2_eop_grant", 32'(grant),     32'h4);
    tick();
    check_eq("ep2_released", 32'(grant), 32'h0);
    // rr_ptr is now 3, so EP3 beats EP0.
    req_valid = 4'b1001;
    #1;
    tick();
    check_eq("rr_ptr3_pick", 32'(grant), 32'h8);
    check_eq("rr_ptr3_epnum", 32'(out_epnum), 32'h3);

    // EP0 and EP3 stream: 16-byte bursts, one idle cycle between.
    do_reset();
    req_valid = 4'b1001;
    req_data  = 32'hA3_00_00_A0;
    #1;
    for (int c = 0; c < 36; c++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      if (c == 0 || c == 17 || c == 34) begin
        eg = 4'b0000; ed = 8'h00;
      end else if (c < 17 || c >= 35) begin
        eg = 4'b0001; ed = 8'hA0;
      end else begin
        eg = 4'b1000; ed = 8'hA3;
      end
      check_eq($sformatf("burst_grant_c%0d", c), 32'(grant),    32'(eg));
      check_eq($sformatf("burst_data_c%0d", c),  32'(out_data), 32'(ed));
      tick();
    end

    // EP1 under backpressure: out_ready 1,0,0,1.
    do_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h51;
    #1;
    tick();
    check_eq("bp_g0_data",  32'(out_data),  32'h51);
    check_eq("bp_g0_ready", 32'(req_ready), 32'h2);
    tick();
    req_data[15:8] = 8'h52;
    out_ready = 1'b0;
    #1;
    check_eq("bp_g1_ready", 32'(req_ready), 32'h0);
    check_eq("bp_g1_valid", 32'(out_valid), 32'h1);
    check_eq("bp_g1_data",  32'(out_data),  32'h52);
    tick();
    check_eq("bp_g2_grant", 32'(grant),    32'h2);
    check_eq("bp_g2_data",  32'(out_data), 32'h52);
    tick();
    out_ready = 1'b1;
    #1;
    check_eq("bp_g3_grant", 32'(grant),     32'h2);
    check_eq("bp_g3_data",  32'(out_data),  32'h52);
    check_eq("bp_g3_ready", 32'(req_ready), 32'h2);
    tick();
    req_data[15:8] = 8'h53;
    req_valid = 4'b0000;
    #1;
    check_eq("bp_eop_grant", 32'(grant), 32'h2);
    tick();
    check_eq("bp_released", 32'(grant), 32'h0);

    // Reset mid-burst after five EP1 bytes.
    do_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h70;
    #1;
    tick();
    for (int b = 0; b < 5; b++) tick();
    check_eq("mid_valid_pre", 32'(out_valid), 32'h1);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_grant", 32'(grant),     32'h0);
    check_eq("mid_rst_busy",  32'(busy),      32'h0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    resetn = 1'b1;
    #1;
    check_eq("mid_idle_grant", 32'(grant), 32'h0);
    tick();
    check_eq("mid_regrant", 32'(grant),     32'h2);
    check_eq("mid_epnum",   32'(out_epnum), 32'h1);

    // All four EPs with 1-byte packets: grant order 0,1,2,3,0.
    do_reset();
    req_data = 32'h63_62_61_60;
    for (int r = 0; r < 5; r++) begin
      int unsigned ep;
      logic [3:0] oh;
      ep = 32'(r % 4);
      oh = 4'b0001 << ep;
      req_valid = 4'b1111;
      #1;
      check_eq($sformatf("rot%0d_idle", r), 32'(grant), 32'h0);
      tick();
      check_eq($sformatf("rot%0d_grant", r), 32'(grant),     32'(oh));
      check_eq($sformatf("rot%0d_epnum", r), 32'(out_epnum), ep);
      check_eq($sformatf("rot%0d_data", r),  32'(out_data),  32'h60 + ep);
      tick();
      req_valid = 4'b1111 & ~oh;
      #1;
      check_eq($sformatf("rot%0d_eop", r), 32'(out_valid), 32'h0);
      tick();
    end

`ifdef C3DEMO_SEND_ARB_PRIO_EN
    do_reset();
    prio_mask = 4'b1000;
    req_valid = 4'b1001;
    #1;
    tick();
    check_eq("prio_ep3_first", 32'(grant), 32'h8);
    do_reset();
    prio_mask = 4'b0000;
    req_valid = 4'b1001;
    #1;
    tick();
    check_eq("noprio_ep0_first", 32'(grant), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c3demo_send_arbiter.md
Name: c3demo_send_arbiter

Overview:
- Round-robin, burst-limited arbiter for the send side of the RasPi link.
- Shares the single byte-wide send stream (valid/ready/tdata plus endpoint number) between NUM_EP endpoint producers.
- Replaces the fixed highest-index priority, so that one busy endpoint cannot starve the others.
- Sits between the endpoint producers and the send FIFO of the RasPi interface.

Parameters:
- NUM_EP, 4, number of requesting endpoints (1..8).
- MAX_BURST, 16, maximum bytes transferred per grant before the grant rotates (>=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_EP  per-endpoint byte valid
- req_ready  out  NUM_EP  per-endpoint byte accepted
- req_data  in  8*NUM_EP  per-endpoint byte; endpoint i uses bits [8i+7:8i]
- out_valid  out  1  byte valid toward the send FIFO
- out_ready  in  1  send FIFO not full
- out_data  out  8  byte from the granted endpoint
- out_epnum  out  8  index of the granted endpoint, zero-extended
- grant  out  NUM_EP  one-hot current owner; all zero when idle
- busy  out  1  high in GRANT state

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset (async, immediate):
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
  - Hence out_valid=0, req_ready=0, busy=0, out_epnum=0, out_data=0.
- Handshake: a transfer occurs in any cycle with out_valid && out_ready.
- Producer rule: once req_valid is high it holds until accepted.
- State IDLE:
  - No output is valid.
  - If any req_valid is high, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_EP.
  - Register it into grant, clear burst_cnt, go to GRANT.
  - Arbitration latency is 1 cycle: the request is seen in IDLE and data can flow the next cycle.
  - If there are no requests, stay in IDLE.
- State GRANT (owner g):
  - out_valid = req_valid[g], out_data = req_data[g], out_epnum = g.
  - req_ready[g] = out_ready; all other req_ready bits are 0.
  - These paths are combinational from registered grant; there is no data register.
  - On each transfer, burst_cnt increments.
- Release to IDLE, with rr_ptr <= (g+1) mod NUM_EP, when either:
  - a transfer occurs with burst_cnt == MAX_BURST-1, or
  - req_valid[g] is low in a cycle (end of packet; no transfer that cycle).
- out_ready low with req_valid[g] high: hold, no count change, no release. Backpressure never rotates the grant.
- Minimum one bubble cycle (IDLE) between consecutive grants, including a re-grant to the same endpoint.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST)+1 bits.
  - rr_ptr is $clog2(NUM_EP) bits, minimum 1.
  - Wrap from NUM_EP-1 to 0 is explicit, not a power-of-2 overflow.
- MAX_BURST=1: the grant rotates after every byte.
- NUM_EP=1: the single endpoint is re-granted after each release.
- Reset mid-burst: the grant drops asynchronously; an in-flight byte is not transferred; the producer still holds valid and is re-arbitrated from rr_ptr=0.

Optional Feature:
- Macro: C3DEMO_SEND_ARB_PRIO_EN.
- Defined:
  - Adds input prio_mask [NUM_EP].
  - In IDLE, if any (req_valid & prio_mask) is set, the round-robin scan considers only those bits; otherwise it considers all req_valid.
  - Burst limit and release rules are unchanged. A granted low-priority burst is not preempted.
- Undefined:
  - The port is absent.
  - Plain round-robin over all requesters.

Test Plan:
- Reset, then EP2 alone sends 3 bytes (0x11,0x22,0x33) with out_ready=1 -> grant=0100 one cycle after valid, out_epnum=2, bytes out in order, release after the 3rd, rr_ptr=3.
- EP0 and EP3 stream continuously, MAX_BURST=16 -> alternating grants of exactly 16 bytes each (EP0 first from rr_ptr=0, then EP3), one idle cycle between grants.
- EP1 granted, out_ready toggles 1,0,0,1 -> only 2 transfers counted, grant held throughout, no byte duplicated or lost.
- Assert resetn low after 5 of 16 bytes of an EP1 burst -> same-cycle out_valid=0, grant=0, busy=0; after release EP1 (still valid) is regranted, starting from rr_ptr=0 scan.
- All 4 EPs request, each 1-byte packets -> grant order 0,1,2,3,0 with each EP served once per rotation.
- With C3DEMO_SEND_ARB_PRIO_EN, prio_mask=1000, EP0 and EP3 valid -> EP3 granted first; with prio_mask=0000 -> EP0 granted first.
